// File: rtl/product_accumulator_pkg.sv
// Shared types and default widths for the product accumulator stage.
package product_accumulator_pkg;

    localparam int MULT_SIZE     = 16;
    localparam int ACC_W_DEFAULT = 40;
    localparam int COUNT_W       = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/product_accumulator_sat_adder.sv
// Combinational unsigned add that clamps to all ones on carry-out.
module sat_adder #(
    parameter int IN_W  = 32,
    parameter int ACC_W = 40
) (
    input  logic [ACC_W-1:0] acc_i,
    input  logic [IN_W-1:0]  add_i,
    output logic [ACC_W-1:0] sum_o,
    output logic             sat_o
);

    logic [ACC_W:0] full;

    assign full  = {1'b0, acc_i} + {{(ACC_W + 1 - IN_W){1'b0}}, add_i};
    assign sat_o = full[ACC_W];
    assign sum_o = sat_o ? '1 : full[ACC_W-1:0];

endmodule

// File: rtl/product_accumulator.sv
// Sums COUNT consecutive multiplier products with saturation and
// holds the result until the next stage takes it.
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int SIZE  = MULT_SIZE,
    parameter int ACC_W = ACC_W_DEFAULT,
    parameter int COUNT = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*SIZE-1:0]  M,
    input  logic               clear,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   acc_out,
    output logic               overflow,
    output logic [COUNT_W-1:0] count
);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W-1:0]   sum;
    logic               sat;

    sat_adder #(
        .IN_W  (2 * SIZE),
        .ACC_W (ACC_W)
    ) u_add (
        .acc_i (acc_q),
        .add_i (M),
        .sum_o (sum),
        .sat_o (sat)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (clear) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE, ACCUM: begin
                    if (in_valid) begin
                        acc_d   = sum;
                        ovf_d   = ovf_q | sat;
                        cnt_d   = cnt_q + COUNT_W'(1);
                        state_d = (cnt_q == COUNT_W'(COUNT - 1)) ? HOLD : ACCUM;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_d = IDLE;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q != HOLD);
    assign out_valid = (state_q == HOLD);
    assign acc_out   = acc_q;
    assign overflow  = ovf_q;
    assign count     = cnt_q;

endmodule
